gpio_config_shadow: RTL and testbench
=====================================

# gpio_config_shadow

Parametrised successor to the fixed per-pad GPIO default tie-off block. It holds a WIDTH-bit pad configuration word that resets to a per-instance DEFAULTS constant. The word is reprogrammed through a daisy-chainable serial shift register with a guarded commit. The block sits between the housekeeping serial configuration chain and each GPIO pad's control logic; one instance is placed per pad.

## Interface

Parameters:
- WIDTH, 10: configuration word width. Legal range is 2..32.
- DEFAULTS, 10'h087: reset and restore value of both the shift register and the configuration word. Bits 0, 1, 2 and 7 are set.

Ports:
- serial_clock, input, 1: the only clock. All state updates on the rising edge.
- resetn, input, 1: reset. Asynchronous assert, active-low.
- serial_data_in, input, 1: serial bit in, MSB first. Driven by the upstream serial_data_out or by housekeeping.
- serial_shift, input, 1: when high, shift one bit this cycle.
- serial_load, input, 1: commit request.
- restore_defaults, input, 1: synchronous return to DEFAULTS.
- serial_data_out, output, 1: the shift register MSB, driven directly from a flop. Feeds the next block in the chain.
- gpio_config, output, WIDTH: active pad configuration, driven directly from a flop.
- load_done, output, 1: one-cycle pulse when a commit succeeds.
- load_error, output, 1: one-cycle pulse when a commit is rejected.
- chain_state, output, 2: current FSM state. 0 = IDLE, 1 = SHIFT, 2 = ARMED.

## Operation

- **Reset values** (while resetn is low):
  - sreg = DEFAULTS
  - gpio_config = DEFAULTS
  - bit_count = 0
  - state = IDLE
  - load_done = 0, load_error = 0
  - serial_data_out = DEFAULTS[WIDTH-1]
- **Shift:** on serial_shift, sreg <= {sreg[WIDTH-2:0], serial_data_in}.
- **bit_count:**
  - Width is $clog2(WIDTH+1).
  - Increments on each shift and saturates at WIDTH.
  - Saturation is what makes long chains work: a block deep in the chain sees more than WIDTH shifts.
- **FSM:**
  - IDLE: bit_count == 0.
  - SHIFT: 0 < bit_count < WIDTH.
  - ARMED: bit_count == WIDTH.
  - Transitions are driven purely by bit_count after each shift.
- **Commit:** serial_load clears bit_count to 0 and returns the FSM to IDLE in all cases.
  - In ARMED: gpio_config <= sreg, and load_done pulses.
  - In IDLE or SHIFT: gpio_config is unchanged, and load_error pulses.
  - sreg is never modified by a load.
- **Restore:** restore_defaults sets sreg = DEFAULTS, gpio_config = DEFAULTS, bit_count = 0 and state = IDLE. No pulse is generated.
- **Priority in the same cycle:** restore_defaults > serial_load > serial_shift.
  - With load and shift together, the shift is dropped and the commit uses the pre-edge sreg.
  - With restore and load together, neither pulse fires.
- **Reset mid-operation:** a partial shift is discarded and all state returns to the reset values. gpio_config never shows a partially shifted word.

## Timing

- Shift latency: serial_data_in reaches serial_data_out WIDTH cycles after being shifted in. In a chain, each stage adds WIDTH shift cycles.
- Commit latency: gpio_config updates on the edge that samples serial_load, so the new value is visible in the following cycle. load_done and load_error are asserted in that same following cycle, for exactly one cycle.
- Restore latency: one edge.
- Back-to-back loads: the second load always sees bit_count == 0, so it raises load_error.
- serial_shift may be held high continuously. One bit is taken per cycle with no bubble.
- There are no combinational paths from any input to any output.

## Test plan

- **Reset:** release resetn with no activity. Expect gpio_config = 10'h087, serial_data_out = 0, chain_state = 0 and no pulses.
- **Full load:** shift 10'h2A5 MSB first over 10 cycles (chain_state shows 1 and then 2), then pulse serial_load. Expect gpio_config = 10'h2A5 in the next cycle and one load_done pulse.
- **Short load:** shift 7 bits, then load. Expect load_error for one cycle, gpio_config still 10'h087 and chain_state = 0.
- **Two-instance chain:** chain two instances and shift 20 bits, with 10'h3FF followed by 10'h001. Expect the far instance = 10'h3FF, the near instance = 10'h001, and load_done on both. This confirms bit_count saturation.
- **Simultaneous load and shift:** assert serial_load together with serial_shift in ARMED state. Expect the commit to use the pre-shift sreg, the shift to be dropped and bit_count = 0.
- **Restore and mid-operation reset:**
  - After a commit of 10'h2A5, pulse restore_defaults. Expect gpio_config = 10'h087 and no pulse.
  - Assert resetn after 5 shifts. Expect all reset values, and a subsequent load raises load_error.

Source files
------------

// File: rtl/gpio_config_shadow.sv
// gpio_config_shadow
//   Per-pad GPIO configuration shadow. Holds a WIDTH-bit configuration word that
//   resets to DEFAULTS and is reprogrammed through a daisy-chainable serial shift
//   register. The shifted word is committed only after a full WIDTH bits have
//   been seen; a premature commit is rejected.
//
// Ports
//   serial_clock     : clock, all state updates on the rising edge
//   resetn           : asynchronous active-low reset
//   serial_data_in   : serial bit in, MSB first
//   serial_shift     : shift one bit this cycle
//   serial_load      : commit request
//   restore_defaults : synchronous return to DEFAULTS
//   serial_data_out  : shift register MSB, feeds the next block in the chain
//   gpio_config      : active pad configuration word
//   load_done        : one-cycle pulse, commit accepted
//   load_error       : one-cycle pulse, commit rejected
//   chain_state      : 0 = idle, 1 = shifting, 2 = armed
module gpio_config_shadow #(
  parameter int unsigned          WIDTH    = 10,
  parameter logic [WIDTH-1:0]     DEFAULTS = WIDTH'(10'h087)
) (
  input  logic             serial_clock,
  input  logic             resetn,
  input  logic             serial_data_in,
  input  logic             serial_shift,
  input  logic             serial_load,
  input  logic             restore_defaults,
  output logic             serial_data_out,
  output logic [WIDTH-1:0] gpio_config,
  output logic             load_done,
  output logic             load_error,
  output logic [1:0]       chain_state
);

  localparam int unsigned CntWidth = $clog2(WIDTH + 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(WIDTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StArmed = 2'd2;

  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [WIDTH-1:0]    cfg_q, cfg_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    sreg_d = sreg_q;
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = 1'b0;

    // Priority: restore > load > shift. A load drops a coincident shift so the
    // commit sees the pre-edge shift register.
    if (restore_defaults) begin
      sreg_d = DEFAULTS;
      cfg_d  = DEFAULTS;
      cnt_d  = '0;
    end else if (serial_load) begin
      cnt_d = '0;
      if (state_q == StArmed) begin
        cfg_d  = sreg_q;
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (serial_shift) begin
      sreg_d = {sreg_q[WIDTH-2:0], serial_data_in};
      // Saturate so blocks deep in a chain still arm after seeing > WIDTH bits.
      if (cnt_q != CntFull) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end

    // State is a pure function of the updated bit count.
    if (cnt_d == '0) begin
      state_d = StIdle;
    end else if (cnt_d == CntFull) begin
      state_d = StArmed;
    end else begin
      state_d = StShift;
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      sreg_q  <= DEFAULTS;
      cfg_q   <= DEFAULTS;
      cnt_q   <= '0;
      state_q <= StIdle;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign serial_data_out = sreg_q[WIDTH-1];
  assign gpio_config     = cfg_q;
  assign load_done       = done_q;
  assign load_error      = err_q;
  assign chain_state     = state_q;

endmodule

// File: tb/tb_gpio_config_shadow.sv
// Testbench for gpio_config_shadow: two instances chained (u_near fed by the
// bench, u_far fed by u_near), checked every cycle against a behavioural model
// of the serial chain, plus directed checks against constant expectations.
module tb_gpio_config_shadow;

  localparam int unsigned W = 10;
  localparam logic [W-1:0] DEF = 10'h087;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic din = 1'b0;
  logic shift = 1'b0;
  logic load = 1'b0;
  logic restore = 1'b0;

  logic         sdo0, sdo1;
  logic [W-1:0] cfg0, cfg1;
  logic         done0, done1, err0, err1;
  logic [1:0]   st0, st1;

  always #5 clk = ~clk;

  gpio_config_shadow #(.WIDTH(W), .DEFAULTS(DEF)) u_near (
    .serial_clock     (clk),
    .resetn           (resetn),
    .serial_data_in   (din),
    .serial_shift     (shift),
    .serial_load      (load),
    .restore_defaults (restore),
    .serial_data_out  (sdo0),
    .gpio_config      (cfg0),
    .load_done        (done0),
    .load_error       (err0),
    .chain_state      (st0)
  );

  gpio_config_shadow #(.WIDTH(W), .DEFAULTS(DEF)) u_far (
    .serial_clock     (clk),
    .resetn           (resetn),
    .serial_data_in   (sdo0),
    .serial_shift     (shift),
    .serial_load      (load),
    .restore_defaults (restore),
    .serial_data_out  (sdo1),
    .gpio_config      (cfg1),
    .load_done        (done1),
    .load_error       (err1),
    .chain_state      (st1)
  );

  // Reference model: index 0 = near, 1 = far.
  logic [W-1:0] m_sreg [2];
  logic [W-1:0] m_cfg  [2];
  int           m_cnt  [2];
  logic         m_done [2];
  logic         m_err  [2];

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [1:0] state_of(input int cnt);
    if (cnt == 0) return 2'd0;
    if (cnt == int'(W)) return 2'd2;
    return 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sreg[i] = DEF;
      m_cfg[i]  = DEF;
      m_cnt[i]  = 0;
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] old_sreg [2];
    logic bit_in;
    old_sreg[0] = m_sreg[0];
    old_sreg[1] = m_sreg[1];
    for (int i = 0; i < 2; i++) begin
      bit_in    = (i == 0) ? din : old_sreg[0][W-1];
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
      if (restore) begin
        m_sreg[i] = DEF;
        m_cfg[i]  = DEF;
        m_cnt[i]  = 0;
      end else if (load) begin
        if (m_cnt[i] == int'(W)) begin
          m_cfg[i]  = old_sreg[i];
          m_done[i] = 1'b1;
        end else begin
          m_err[i] = 1'b1;
        end
        m_cnt[i] = 0;
      end else if (shift) begin
        m_sreg[i] = W'({old_sreg[i], bit_in});
        m_cnt[i]  = (m_cnt[i] + 1 > int'(W)) ? int'(W) : m_cnt[i] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("near.cfg",   32'(cfg0),  32'(m_cfg[0]));
    chk("near.sdo",   32'(sdo0),  32'(m_sreg[0][W-1]));
    chk("near.state", 32'(st0),   32'(state_of(m_cnt[0])));
    chk("near.done",  32'(done0), 32'(m_done[0]));
    chk("near.err",   32'(err0),  32'(m_err[0]));
    chk("far.cfg",    32'(cfg1),  32'(m_cfg[1]));
    chk("far.sdo",    32'(sdo1),  32'(m_sreg[1][W-1]));
    chk("far.state",  32'(st1),   32'(state_of(m_cnt[1])));
    chk("far.done",   32'(done1), 32'(m_done[1]));
    chk("far.err",    32'(err1),  32'(m_err[1]));
  endtask

  task automatic cycle(input logic s, input logic l, input logic r, input logic d);
    shift   = s;
    load    = l;
    restore = r;
    din     = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    shift   = 1'b0;
    load    = 1'b0;
    restore = 1'b0;
  endtask

  task automatic shift_word(input logic [W-1:0] w);
    for (int i = int'(W) - 1; i >= 0; i--) cycle(1'b1, 1'b0, 1'b0, w[i]);
  endtask

  // Assert reset between edges, check the asynchronous effect, then release.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
  endtask

  logic [W-1:0] word;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;

    // Reset state with no activity
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.cfg",   32'(cfg0), 32'h087);
    chk("rst.sdo",   32'(sdo0), 32'h0);
    chk("rst.state", 32'(st0),  32'h0);
    chk("rst.pulse", 32'({done0, err0}), 32'h0);

    // Full load of 2A5
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("full.state_shift", 32'(st0), 32'h1);
    for (int i = int'(W) - 2; i >= 0; i--) cycle(1'b1, 1'b0, 1'b0, word_2a5(i));
    chk("full.state_armed", 32'(st0), 32'h2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full.cfg",  32'(cfg0),  32'h2A5);
    chk("full.done", 32'(done0), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.done_one_cycle", 32'(done0), 32'h0);

    // Restore after commit: defaults, no pulse
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("restore.cfg",   32'(cfg0), 32'h087);
    chk("restore.pulse", 32'({done0, err0}), 32'h0);

    // Short load: 7 bits then load
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'(i & 1));
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("short.err",   32'(err0), 32'h1);
    chk("short.cfg",   32'(cfg0), 32'h087);
    chk("short.state", 32'(st0),  32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("short.err_one_cycle", 32'(err0), 32'h0);

    // Two-instance chain: 3FF then 001, saturating counters
    shift_word(10'h3FF);
    shift_word(10'h001);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("chain.far_cfg",  32'(cfg1), 32'h3FF);
    chk("chain.near_cfg", 32'(cfg0), 32'h001);
    chk("chain.done",     32'({done1, done0}), 32'h3);

    // Load with coincident shift in armed state: shift dropped
    word = 10'h15A;
    shift_word(word);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ldsh.cfg",   32'(cfg0), 32'h15A);
    chk("ldsh.state", 32'(st0),  32'h0);
    chk("ldsh.sdo",   32'(sdo0), 32'h0);
    // Back-to-back load is rejected
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b.err", 32'(err0), 32'h1);
    chk("b2b.cfg", 32'(cfg0), 32'h15A);

    // Restore and load together: neither pulse
    shift_word(10'h0F0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rstld.pulse", 32'({done0, err0}), 32'h0);
    chk("rstld.cfg",   32'(cfg0), 32'h087);

    // Reset after 5 shifts, then load is rejected
    shift_word(10'h3C3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("midrst.cfg",   32'(cfg0), 32'h087);
    chk("midrst.state", 32'(st0),  32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst.err", 32'(err0), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 13) == 0),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic word_2a5(input int i);
    logic [W-1:0] w;
    w = 10'h2A5;
    return w[i];
  endfunction

endmodule
